// File: rtl/uparc_fetch_pq.sv
// Instruction fetch stage with a prefetch queue: issues sequential IFU reads ahead of
// decode, buffers up to DEPTH {instr, pc, errors} entries, flushes and redirects on jump/exception.
module uparc_fetch_pq #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INSTR_WIDTH = 32,
  parameter int                    DEPTH       = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = {ADDR_WIDTH{1'b0}}
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_WIDTH-1:0]  i_jump_addr,
  input  logic                   i_jump_valid,
  input  logic [ADDR_WIDTH-1:0]  i_except_haddr,
  input  logic                   i_except_valid,
  input  logic                   i_exec_stall,
  input  logic                   i_mem_stall,
  input  logic                   i_nullify,
  output logic                   o_fetch_stall,
  output logic                   o_bus_error,
  output logic                   o_addr_error,
  output logic [ADDR_WIDTH-1:0]  o_addr,
  output logic                   o_rd_cmd,
  input  logic                   i_busy,
  input  logic                   i_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] i_instr_dat,
  input  logic                   i_err_align,
  input  logic                   i_err_bus,
  output logic                   o_valid,
  output logic [INSTR_WIDTH-1:0] o_instr,
  output logic [ADDR_WIDTH-1:0]  o_pc
);
  localparam int              PW      = $clog2(DEPTH);
  localparam int              CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

  logic [ADDR_WIDTH-1:0]  fetch_pc_r, req_pc_r;
  logic                   inflight_r, drop_r, halt_r;
  logic [PW-1:0]          rd_ptr_r, wr_ptr_r;
  logic [CW-1:0]          count_r;
  logic [INSTR_WIDTH-1:0] q_instr_r [DEPTH];
  logic [ADDR_WIDTH-1:0]  q_pc_r    [DEPTH];
  logic                   q_bus_r   [DEPTH];
  logic                   q_align_r [DEPTH];

  logic                   redirect_s, ready_s, pop_s, resp_s, push_s, free_s, rsp_err_s;
  logic                   issue_s, head_err_s;
  logic [ADDR_WIDTH-1:0]  target_s, issue_addr_s, fetch_pc_next_s;
  logic [CW-1:0]          cnt_next_s;

  assign redirect_s = i_except_valid || i_jump_valid;
  assign target_s   = i_except_valid ? i_except_haddr : i_jump_addr;
  assign ready_s    = !i_exec_stall && !i_mem_stall;
  assign o_valid    = (count_r != {CW{1'b0}});
  assign pop_s      = o_valid && ready_s && !redirect_s;
  // A response only counts against a request we actually issued since reset.
  assign resp_s     = i_rsp_valid && inflight_r;
  assign push_s     = resp_s && !drop_r && !redirect_s;
  assign free_s     = !inflight_r || i_rsp_valid;
  assign rsp_err_s  = i_err_bus || i_err_align;
  assign head_err_s = q_bus_r[rd_ptr_r] || q_align_r[rd_ptr_r];

  // Queue occupancy after this edge's flush/push/pop.
  always_comb begin
    cnt_next_s = count_r;
    if (redirect_s) begin
      cnt_next_s = {CW{1'b0}};
    end else if (push_s && !pop_s) begin
      cnt_next_s = count_r + CW'(1);
    end else if (!push_s && pop_s) begin
      cnt_next_s = count_r - CW'(1);
    end else begin
      cnt_next_s = count_r;
    end
  end

  // Issue decision and next fetch address; a faulting response stops fetch at once.
  always_comb begin
    issue_s         = 1'b0;
    issue_addr_s    = fetch_pc_r;
    fetch_pc_next_s = fetch_pc_r;
    if (redirect_s) begin
      if (free_s && !i_busy) begin
        issue_s         = 1'b1;
        issue_addr_s    = target_s;
        fetch_pc_next_s = target_s + ADDR_WIDTH'(4);
      end else begin
        fetch_pc_next_s = target_s;
      end
    end else if (!halt_r && !(push_s && rsp_err_s) && !i_busy && free_s && (cnt_next_s < DEPTH_C)) begin
      issue_s         = 1'b1;
      fetch_pc_next_s = fetch_pc_r + ADDR_WIDTH'(4);
    end else begin
      issue_s = 1'b0;
    end
  end

  // Head presentation: NOP when empty, redirecting, nullified or faulted.
  always_comb begin
    o_instr = {INSTR_WIDTH{1'b0}};
    if (o_valid && !redirect_s && !i_nullify && !head_err_s) begin
      o_instr = q_instr_r[rd_ptr_r];
    end else begin
      o_instr = {INSTR_WIDTH{1'b0}};
    end
  end

  assign o_pc          = o_valid ? q_pc_r[rd_ptr_r] : {ADDR_WIDTH{1'b0}};
  assign o_bus_error   = o_valid && q_bus_r[rd_ptr_r];
  assign o_addr_error  = o_valid && q_align_r[rd_ptr_r];
  assign o_fetch_stall = !o_valid;

  // Fetch control, request tracking and IFU command registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_r <= RESET_PC;
      req_pc_r   <= {ADDR_WIDTH{1'b0}};
      inflight_r <= 1'b0;
      drop_r     <= 1'b0;
      halt_r     <= 1'b0;
      o_rd_cmd   <= 1'b0;
      o_addr     <= {ADDR_WIDTH{1'b0}};
    end else begin
      fetch_pc_r <= fetch_pc_next_s;
      o_rd_cmd   <= issue_s;
      if (issue_s) begin
        o_addr     <= issue_addr_s;
        req_pc_r   <= issue_addr_s;
        inflight_r <= 1'b1;
      end else if (resp_s) begin
        inflight_r <= 1'b0;
      end
      if (redirect_s && inflight_r && !i_rsp_valid) begin
        drop_r <= 1'b1;
      end else if (resp_s) begin
        drop_r <= 1'b0;
      end
      if (redirect_s) begin
        halt_r <= 1'b0;
      end else if (push_s && rsp_err_s) begin
        halt_r <= 1'b1;
      end
    end
  end

  // Circular queue storage and pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        q_instr_r[i] <= {INSTR_WIDTH{1'b0}};
        q_pc_r[i]    <= {ADDR_WIDTH{1'b0}};
        q_bus_r[i]   <= 1'b0;
        q_align_r[i] <= 1'b0;
      end
    end else begin
      count_r <= cnt_next_s;
      if (redirect_s) begin
        rd_ptr_r <= wr_ptr_r;
      end else begin
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + PW'(1);
        end
        if (push_s) begin
          q_instr_r[wr_ptr_r] <= i_instr_dat;
          q_pc_r[wr_ptr_r]    <= req_pc_r;
          q_bus_r[wr_ptr_r]   <= i_err_bus;
          q_align_r[wr_ptr_r] <= i_err_align;
          wr_ptr_r            <= wr_ptr_r + PW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_uparc_fetch_pq.sv
// Directed bench for uparc_fetch_pq with a simple single-cycle IFU model.
module tb_uparc_fetch_pq;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_jump_addr, i_except_haddr, i_instr_dat;
  logic        i_jump_valid, i_except_valid, i_exec_stall, i_mem_stall, i_nullify;
  logic        i_busy, i_rsp_valid, i_err_align, i_err_bus;
  logic        o_fetch_stall, o_bus_error, o_addr_error, o_rd_cmd, o_valid;
  logic [31:0] o_addr, o_instr, o_pc;

  int   total = 0;
  int   bad   = 0;
  bit   ifu_auto = 1'b0;
  bit   bus_en = 1'b0, al_en = 1'b0;
  logic [31:0] bus_addr = 32'h0, al_addr = 32'h0;

  uparc_fetch_pq #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .i_jump_addr(i_jump_addr), .i_jump_valid(i_jump_valid),
    .i_except_haddr(i_except_haddr), .i_except_valid(i_except_valid),
    .i_exec_stall(i_exec_stall), .i_mem_stall(i_mem_stall), .i_nullify(i_nullify),
    .o_fetch_stall(o_fetch_stall), .o_bus_error(o_bus_error), .o_addr_error(o_addr_error),
    .o_addr(o_addr), .o_rd_cmd(o_rd_cmd), .i_busy(i_busy),
    .i_rsp_valid(i_rsp_valid), .i_instr_dat(i_instr_dat),
    .i_err_align(i_err_align), .i_err_bus(i_err_bus),
    .o_valid(o_valid), .o_instr(o_instr), .o_pc(o_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  // Advance one cycle; the IFU answers a command in the same cycle it appears.
  task automatic step();
    @(posedge clk); #1;
    if (ifu_auto) begin
      i_rsp_valid = o_rd_cmd;
      i_instr_dat = instr_of(o_addr);
      i_err_bus   = o_rd_cmd && bus_en && (o_addr == bus_addr);
      i_err_align = o_rd_cmd && al_en && (o_addr == al_addr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (o_rd_cmd !== 1'b0) begin bad++; $display("FAIL reset_rd_cmd got %0b want 0", o_rd_cmd); end
    total++; if (o_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got %h want 0", o_addr); end
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %0b want 0", o_valid); end
    total++; if (o_instr !== 32'h0) begin bad++; $display("FAIL reset_instr got %h want 0", o_instr); end
    total++; if (o_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got %h want 0", o_pc); end
    total++; if (o_fetch_stall !== 1'b1) begin bad++; $display("FAIL reset_stall got %0b want 1", o_fetch_stall); end
    total++; if ({o_bus_error, o_addr_error} !== 2'b00) begin bad++; $display("FAIL reset_err got %b want 00", {o_bus_error, o_addr_error}); end
    rst = 1'b0;
    ifu_auto = 1'b1;
  endtask

  task automatic test_stream();
    for (int k = 1; k <= 5; k++) begin
      step();
      total++; if (o_rd_cmd !== 1'b1 || o_addr !== 32'(4 * (k - 1))) begin
        bad++; $display("FAIL stream_cmd k=%0d got %0b/%h want 1/%h", k, o_rd_cmd, o_addr, 32'(4 * (k - 1)));
      end
      if (k >= 2) begin
        total++; if (o_valid !== 1'b1 || o_pc !== 32'(4 * (k - 2)) || o_instr !== instr_of(32'(4 * (k - 2)))) begin
          bad++; $display("FAIL stream_head k=%0d got %0b/%h/%h want 1/%h", k, o_valid, o_pc, o_instr, 32'(4 * (k - 2)));
        end
      end
    end
  endtask

  task automatic test_stall();
    i_exec_stall = 1'b1;
    for (int s = 1; s <= 10; s++) begin
      if (s == 6) begin i_exec_stall = 1'b0; i_mem_stall = 1'b1; end
      step();
      total++; if (o_rd_cmd !== (s <= 2)) begin bad++; $display("FAIL stall_cmd s=%0d got %0b want %0b", s, o_rd_cmd, (s <= 2)); end
      total++; if (o_valid !== 1'b1 || o_pc !== 32'hC) begin bad++; $display("FAIL stall_head s=%0d got %0b/%h want 1/c", s, o_valid, o_pc); end
    end
    i_mem_stall = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      step();
      total++; if (o_valid !== 1'b1 || o_pc !== 32'(12 + 4 * j)) begin
        bad++; $display("FAIL drain_pc j=%0d got %0b/%h want 1/%h", j, o_valid, o_pc, 32'(12 + 4 * j));
      end
    end
  endtask

  task automatic test_jump_pending();
    ifu_auto = 1'b0;
    i_rsp_valid = 1'b0;
    i_jump_addr = 32'h100; i_jump_valid = 1'b1;
    #1;
    total++; if (o_valid !== 1'b1 || o_instr !== 32'h0) begin bad++; $display("FAIL redirect_nop got %0b/%h want 1/0", o_valid, o_instr); end
    step();
    i_jump_valid = 1'b0;
    total++; if (o_valid !== 1'b0 || o_rd_cmd !== 1'b0) begin bad++; $display("FAIL jump_wait got %0b/%0b want 0/0", o_valid, o_rd_cmd); end
    i_rsp_valid = 1'b1; i_instr_dat = instr_of(32'h30);
    ifu_auto = 1'b1;
    step();
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL stale_dropped got valid %0b want 0", o_valid); end
    total++; if (o_rd_cmd !== 1'b1 || o_addr !== 32'h100) begin bad++; $display("FAIL jump_cmd got %0b/%h want 1/100", o_rd_cmd, o_addr); end
    step();
    total++; if (o_valid !== 1'b1 || o_pc !== 32'h100 || o_instr !== instr_of(32'h100)) begin
      bad++; $display("FAIL jump_head got %0b/%h/%h want 1/100/%h", o_valid, o_pc, o_instr, instr_of(32'h100));
    end
  endtask

  task automatic test_jump_except();
    i_jump_addr = 32'h100; i_jump_valid = 1'b1;
    i_except_haddr = 32'h180; i_except_valid = 1'b1;
    step();
    i_jump_valid = 1'b0; i_except_valid = 1'b0;
    total++; if (o_rd_cmd !== 1'b1 || o_addr !== 32'h180 || o_valid !== 1'b0) begin
      bad++; $display("FAIL except_cmd got %0b/%h/%0b want 1/180/0", o_rd_cmd, o_addr, o_valid);
    end
    step();
    total++; if (o_valid !== 1'b1 || o_pc !== 32'h180) begin bad++; $display("FAIL except_head got %0b/%h want 1/180", o_valid, o_pc); end
  endtask

  task automatic test_bus_error();
    bus_en = 1'b1; bus_addr = 32'h8;
    i_jump_addr = 32'h0; i_jump_valid = 1'b1;
    step();
    i_jump_valid = 1'b0;
    repeat (3) step();
    total++; if (o_valid !== 1'b1 || o_pc !== 32'h8 || o_bus_error !== 1'b1 || o_addr_error !== 1'b0 || o_instr !== 32'h0) begin
      bad++; $display("FAIL bus_err_head got %0b/%h/%0b/%0b/%h want 1/8/1/0/0", o_valid, o_pc, o_bus_error, o_addr_error, o_instr);
    end
    total++; if (o_rd_cmd !== 1'b0) begin bad++; $display("FAIL bus_err_cmd got %0b want 0", o_rd_cmd); end
    for (int h = 0; h < 4; h++) begin
      step();
      total++; if (o_rd_cmd !== 1'b0 || o_fetch_stall !== 1'b1) begin
        bad++; $display("FAIL halted h=%0d got cmd %0b stall %0b want 0/1", h, o_rd_cmd, o_fetch_stall);
      end
    end
    bus_en = 1'b0;
    i_jump_addr = 32'h40; i_jump_valid = 1'b1;
    step();
    i_jump_valid = 1'b0;
    total++; if (o_rd_cmd !== 1'b1 || o_addr !== 32'h40) begin bad++; $display("FAIL resume_cmd got %0b/%h want 1/40", o_rd_cmd, o_addr); end
    step();
    total++; if (o_valid !== 1'b1 || o_pc !== 32'h40 || o_bus_error !== 1'b0 || o_instr !== instr_of(32'h40)) begin
      bad++; $display("FAIL resume_head got %0b/%h/%0b/%h want 1/40/0/%h", o_valid, o_pc, o_bus_error, o_instr, instr_of(32'h40));
    end
  endtask

  task automatic test_align_error();
    al_en = 1'b1; al_addr = 32'h204;
    i_jump_addr = 32'h200; i_jump_valid = 1'b1;
    step();
    i_jump_valid = 1'b0;
    repeat (2) step();
    total++; if (o_pc !== 32'h204 || o_addr_error !== 1'b1 || o_bus_error !== 1'b0 || o_instr !== 32'h0 || o_rd_cmd !== 1'b0) begin
      bad++; $display("FAIL align_err got %h/%0b/%0b/%h/%0b want 204/1/0/0/0", o_pc, o_addr_error, o_bus_error, o_instr, o_rd_cmd);
    end
    al_en = 1'b0;
  endtask

  task automatic test_nullify();
    i_jump_addr = 32'h0; i_jump_valid = 1'b1;
    step();
    i_jump_valid = 1'b0;
    repeat (2) step();
    i_nullify = 1'b1;
    #1;
    total++; if (o_valid !== 1'b1 || o_pc !== 32'h4 || o_instr !== 32'h0) begin
      bad++; $display("FAIL nullify_nop got %0b/%h/%h want 1/4/0", o_valid, o_pc, o_instr);
    end
    step();
    i_nullify = 1'b0;
    #1;
    total++; if (o_valid !== 1'b1 || o_pc !== 32'h8 || o_instr !== instr_of(32'h8)) begin
      bad++; $display("FAIL nullify_next got %0b/%h/%h want 1/8/%h", o_valid, o_pc, o_instr, instr_of(32'h8));
    end
  endtask

  task automatic test_reset_mid();
    ifu_auto = 1'b0;
    i_rsp_valid = 1'b0;
    rst = 1'b1;
    #1;
    total++; if (o_rd_cmd !== 1'b0 || o_valid !== 1'b0 || o_pc !== 32'h0 || o_addr !== 32'h0) begin
      bad++; $display("FAIL async_reset got %0b/%0b/%h/%h want 0/0/0/0", o_rd_cmd, o_valid, o_pc, o_addr);
    end
    step();
    rst = 1'b0;
    i_rsp_valid = 1'b1; i_instr_dat = 32'hDEAD_BEEF;
    ifu_auto = 1'b1;
    step();
    total++; if (o_valid !== 1'b0 || o_rd_cmd !== 1'b1 || o_addr !== 32'h0) begin
      bad++; $display("FAIL late_rsp got %0b/%0b/%h want 0/1/0", o_valid, o_rd_cmd, o_addr);
    end
    step();
    total++; if (o_valid !== 1'b1 || o_pc !== 32'h0 || o_instr !== instr_of(32'h0)) begin
      bad++; $display("FAIL restart_head got %0b/%h/%h want 1/0/%h", o_valid, o_pc, o_instr, instr_of(32'h0));
    end
  endtask

  initial begin
    rst = 1'b1;
    i_jump_addr = 32'h0; i_jump_valid = 1'b0;
    i_except_haddr = 32'h0; i_except_valid = 1'b0;
    i_exec_stall = 1'b0; i_mem_stall = 1'b0; i_nullify = 1'b0;
    i_busy = 1'b0; i_rsp_valid = 1'b0; i_instr_dat = 32'h0;
    i_err_align = 1'b0; i_err_bus = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_jump_pending();
    test_jump_except();
    test_bus_error();
    test_align_error();
    test_nullify();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uparc_fetch_pq.md
# uparc_fetch_pq

Parametrised instruction fetch stage with a prefetch queue, next generation of the single-request fetch stage. It runs ahead of decode, issuing sequential reads to the IFU and buffering up to DEPTH fetched instructions with their PCs and error flags. Jumps and exceptions flush the queue and redirect fetch. It sits between the control unit/decode stage and the IFU.

## Interface
- ADDR_WIDTH, 32, address/PC width
- INSTR_WIDTH, 32, instruction width
- DEPTH, 4, queue entries; power of two, at least 2
- RESET_PC, 0, first fetch address after reset
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- i_jump_addr  in  ADDR_WIDTH  jump target
- i_jump_valid  in  1  redirect to i_jump_addr
- i_except_haddr  in  ADDR_WIDTH  exception handler address
- i_except_valid  in  1  redirect to i_except_haddr; has priority over jump
- i_exec_stall, i_mem_stall  in  1 each  downstream stall
- i_nullify  in  1  present the consumed head as NOP
- o_fetch_stall  out  1  queue empty (equals !o_valid)
- o_bus_error, o_addr_error  out  1 each  error flags of the head entry, qualified by o_valid
- o_addr  out  ADDR_WIDTH  IFU read address
- o_rd_cmd  out  1  single-cycle IFU read command
- i_busy  in  1  IFU cannot accept a command
- i_rsp_valid  in  1  IFU response strobe
- i_instr_dat  in  INSTR_WIDTH  response data
- i_err_align, i_err_bus  in  1 each  response error, qualified by i_rsp_valid
- o_valid  out  1  head entry present
- o_instr  out  INSTR_WIDTH  head instruction; NOP (all zeros) when !o_valid, on error, or on nullify
- o_pc  out  ADDR_WIDTH  head PC; 0 when !o_valid

## Operation
- Registers:
  - fetch_pc
  - inflight (one outstanding IFU request at most)
  - drop (discard the next response)
  - halt
  - circular queue of DEPTH entries {instr, pc, err_bus, err_align}, with rd_ptr, wr_ptr and count (clog2(DEPTH+1) bits)
- Pointers wrap modulo DEPTH. fetch_pc increments by 4 and wraps modulo 2^ADDR_WIDTH.
- Pop:
  - ready = !i_exec_stall && !i_mem_stall.
  - The head is consumed at an edge when o_valid && ready.
- Push:
  - An entry is pushed at an edge when i_rsp_valid && !drop.
  - The entry's pc is the address of the request; errors are stored in the entry.
  - If either error is set, halt is set.
- Issue at an edge requires all of the following:
  - !halt
  - !i_busy
  - inflight cleared or i_rsp_valid this cycle
  - count after this edge's push/pop < DEPTH
- On issue:
  - o_rd_cmd=1 and o_addr=fetch_pc for the following cycle.
  - inflight is set.
  - fetch_pc advances by 4.
- Redirect (i_except_valid || i_jump_valid) at an edge:
  - Target is the exception address if i_except_valid, otherwise the jump address.
  - The queue is flushed: count=0 and pointers equalised. No push and no pop happen at that edge.
  - halt is cleared.
  - If a request is outstanding and its response is not arriving this cycle, drop is set.
  - If nothing remains outstanding, the target is issued at the same edge (o_addr=target) and fetch_pc becomes target+4.
  - Otherwise fetch_pc becomes the target and is issued later.
- drop clears when the discarded response arrives; that response's errors are ignored.
- While any redirect is asserted, o_instr=NOP and no pop occurs.
- Nullify: with i_nullify, o_instr=NOP. The head still pops normally when ready.
- Error head:
  - o_instr=NOP and the matching error output is 1.
  - The head pops like any entry.
  - Recovery is only by redirect.

## Timing
- Reset values:
  - o_rd_cmd=0, o_addr=0, o_valid=0, o_instr=0, o_pc=0
  - o_fetch_stall=1, errors 0
  - fetch_pc=RESET_PC, inflight, drop and halt all 0
- First o_rd_cmd (o_addr=RESET_PC) is in the cycle after the first edge with rst low, if !i_busy.
- Latency:
  - An IFU response pushed at edge E gives o_valid in the cycle after E. There is no combinational bypass.
  - A redirect with nothing outstanding takes at least 2 cycles from the redirect edge to o_valid of the target.
- Throughput: with single-cycle IFU responses, one request every cycle and one instruction per cycle sustained.
- Full queue: issue stops when count would reach DEPTH. A simultaneous pop makes room in the same edge.
- Simultaneous push, pop and issue at one edge is legal; count is unchanged.
- Reset mid-request: all state clears immediately; a late IFU response with inflight=0 is ignored.

## Test plan
- Reset release, i_busy=0, 1-cycle IFU, ready=1 -> o_rd_cmd with addresses 0,4,8,… on consecutive cycles; o_pc follows 0,4,8 with o_valid continuous.
- Stall 10 cycles, DEPTH=4 -> exactly 4 entries buffered and o_rd_cmd stops; on release, PCs come out in order with none lost.
- Jump to 0x100 while a response is pending -> stale response discarded; next o_pc=0x100; no NOP or stale instruction with o_valid.
- Jump and exception asserted together (jump 0x100, exception 0x180) -> fetch resumes at 0x180.
- i_err_bus on the response for 0x8 -> head at pc 0x8 shows o_bus_error=1 and o_instr=0; no further o_rd_cmd until a redirect to 0x40, which resumes fetching.
- i_nullify with head pc 0x4 -> o_instr=0; the entry is consumed; the next o_pc is 0x8.
